// File: rtl/game_judge.sv
// rtl/game_judge.sv - tic-tac-toe board judge: scans nine cells, reports winner/draw
//
// Purpose: on `start` (sampled in IDLE) reads cells 0..8 from the game state
// memory, captures them into a local 9x2 board register, evaluates the eight
// lines and registers the outcome, then pulses `done` for one cycle.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   start     in   request an evaluation (IDLE only, never queued)
//   rd_addr   out  [3:0] cell address to the memory (0..8)
//   rd_data   in   [1:0] cell contents: 00 empty, 01 P1, 10 P2, 11 cursor (empty)
//   busy      out  high from the first READ cycle through EVAL
//   done      out  one-cycle pulse, results valid in the same cycle
//   winner    out  [1:0] 00 none, 01 P1, 10 P2, 11 both own a line
//   draw      out  board full and no owned line
//   win_line  out  [3:0] 1 + lowest owned line index, 0 when none
//                  (present only when GAME_JUDGE_WIN_LINE_EN is defined)
//
// Parameter RD_LATENCY (0 or 1): cycles from rd_addr to valid rd_data.
// Optional feature macro: GAME_JUDGE_WIN_LINE_EN.

module game_judge #(
    parameter int RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] rd_addr,
    input  logic [1:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic       draw
`ifdef GAME_JUDGE_WIN_LINE_EN
    ,
    output logic [3:0] win_line
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_EVAL,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rd_addr_q, rd_addr_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] winner_q, winner_d;
    logic       draw_q, draw_d;
    logic [1:0] board_q [9];
    logic [1:0] board_d [9];

    // Delayed copy of the READ address, used to place late-arriving data
    // when the memory has one cycle of read latency.
    logic       cap_vld_q, cap_vld_d;
    logic [3:0] cap_addr_q, cap_addr_d;

    logic [7:0] p1_line;
    logic [7:0] p2_line;
    logic       board_full;

`ifdef GAME_JUDGE_WIN_LINE_EN
    logic [3:0] win_line_q, win_line_d;
    logic [3:0] line_idx;
`endif

    function automatic logic owns(input logic [1:0] a, input logic [1:0] b,
                                  input logic [1:0] c, input logic [1:0] code);
        return (a == code) && (b == code) && (c == code);
    endfunction

    // ------------------------------------------------------------------
    // Board capture
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            board_d[k] = board_q[k];
        end
        cap_vld_d  = (state_q == S_READ);
        cap_addr_d = rd_addr_q;
        if (RD_LATENCY == 0) begin
            if (state_q == S_READ) begin
                board_d[rd_addr_q] = rd_data;
            end
        end else begin
            // Data for the address driven last cycle; the final cell lands
            // during WAIT so EVAL always sees a fully rewritten board.
            if (cap_vld_q) begin
                board_d[cap_addr_q] = rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line evaluation (purely combinational on the captured board)
    // Line order: rows 0-2, columns 3-5, main diagonal 6, anti-diagonal 7.
    // ------------------------------------------------------------------
    always_comb begin
        p1_line[0] = owns(board_q[0], board_q[1], board_q[2], 2'b01);
        p1_line[1] = owns(board_q[3], board_q[4], board_q[5], 2'b01);
        p1_line[2] = owns(board_q[6], board_q[7], board_q[8], 2'b01);
        p1_line[3] = owns(board_q[0], board_q[3], board_q[6], 2'b01);
        p1_line[4] = owns(board_q[1], board_q[4], board_q[7], 2'b01);
        p1_line[5] = owns(board_q[2], board_q[5], board_q[8], 2'b01);
        p1_line[6] = owns(board_q[0], board_q[4], board_q[8], 2'b01);
        p1_line[7] = owns(board_q[2], board_q[4], board_q[6], 2'b01);

        p2_line[0] = owns(board_q[0], board_q[1], board_q[2], 2'b10);
        p2_line[1] = owns(board_q[3], board_q[4], board_q[5], 2'b10);
        p2_line[2] = owns(board_q[6], board_q[7], board_q[8], 2'b10);
        p2_line[3] = owns(board_q[0], board_q[3], board_q[6], 2'b10);
        p2_line[4] = owns(board_q[1], board_q[4], board_q[7], 2'b10);
        p2_line[5] = owns(board_q[2], board_q[5], board_q[8], 2'b10);
        p2_line[6] = owns(board_q[0], board_q[4], board_q[8], 2'b10);
        p2_line[7] = owns(board_q[2], board_q[4], board_q[6], 2'b10);

        // A cell is occupied only when exactly one bit is set (01 or 10);
        // 00 and the cursor code 11 both count as empty.
        board_full = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (!(board_q[k][0] ^ board_q[k][1])) begin
                board_full = 1'b0;
            end
        end
    end

`ifdef GAME_JUDGE_WIN_LINE_EN
    always_comb begin
        line_idx = 4'd0;
        // Scan downward so the lowest-numbered owned line wins.
        for (int l = 7; l >= 0; l--) begin
            if (p1_line[l] || p2_line[l]) begin
                line_idx = 4'(l + 1);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Control FSM next-state and registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        winner_d  = winner_q;
        draw_d    = draw_q;
`ifdef GAME_JUDGE_WIN_LINE_EN
        win_line_d = win_line_q;
`endif
        case (state_q)
            S_IDLE: begin
                rd_addr_d = 4'd0;
                if (start) begin
                    state_d = S_READ;
                    busy_d  = 1'b1;
                end
            end
            S_READ: begin
                if (rd_addr_q == 4'd8) begin
                    // Address stays at 8 through WAIT/EVAL.
                    state_d = (RD_LATENCY != 0) ? S_WAIT : S_EVAL;
                end else begin
                    rd_addr_d = rd_addr_q + 4'd1;
                end
            end
            S_WAIT: begin
                state_d = S_EVAL;
            end
            S_EVAL: begin
                state_d   = S_DONE;
                rd_addr_d = 4'd0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                winner_d  = {|p2_line, |p1_line};
                draw_d    = board_full && !(|p1_line) && !(|p2_line);
`ifdef GAME_JUDGE_WIN_LINE_EN
                win_line_d = line_idx;
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                rd_addr_d = 4'd0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            winner_q   <= 2'b00;
            draw_q     <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_addr_q <= 4'd0;
            for (int k = 0; k < 9; k++) begin
                board_q[k] <= 2'b00;
            end
`ifdef GAME_JUDGE_WIN_LINE_EN
            win_line_q <= 4'd0;
`endif
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            winner_q   <= winner_d;
            draw_q     <= draw_d;
            cap_vld_q  <= cap_vld_d;
            cap_addr_q <= cap_addr_d;
            for (int k = 0; k < 9; k++) begin
                board_q[k] <= board_d[k];
            end
`ifdef GAME_JUDGE_WIN_LINE_EN
            win_line_q <= win_line_d;
`endif
        end
    end

    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign winner  = winner_q;
    assign draw    = draw_q;
`ifdef GAME_JUDGE_WIN_LINE_EN
    assign win_line = win_line_q;
`endif

endmodule

// File: tb/tb_game_judge.sv
// tb/tb_game_judge.sv - scoreboard bench for game_judge at read latency 0 and 1

module tb_game_judge;

    typedef struct {
        logic [1:0] w;
        logic       dr;
        logic [3:0] wl;
        int         n;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start0, start1;
    logic [3:0] rd_addr0, rd_addr1;
    logic [1:0] rd_data0, rd_data1;
    logic       busy0, busy1, done0, done1, draw0, draw1;
    logic [1:0] winner0, winner1;
    logic [3:0] wl0, wl1;

    logic [1:0] mem [9];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    exp_t       sb [2][$];
    int         nxt [2];

    int lines [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
                         '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
                         '{0, 4, 8}, '{2, 4, 6}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb rd_data0 = (rd_addr0 < 4'd9) ? mem[rd_addr0] : 2'b00;
    always @(posedge clk) rd_data1 <= (rd_addr1 < 4'd9) ? mem[rd_addr1] : 2'b00;

`ifdef GAME_JUDGE_WIN_LINE_EN
    game_judge #(.RD_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .busy(busy0), .done(done0), .winner(winner0), .draw(draw0), .win_line(wl0));
    game_judge #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .winner(winner1), .draw(draw1), .win_line(wl1));
`else
    assign wl0 = 4'd0;
    assign wl1 = 4'd0;
    game_judge #(.RD_LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .busy(busy0), .done(done0), .winner(winner0), .draw(draw0));
    game_judge #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .busy(busy1), .done(done1), .winner(winner1), .draw(draw1));
`endif

    // Reference: outcome straight from the game rules on the current board.
    function automatic exp_t model();
        exp_t e;
        logic p1 = 1'b0;
        logic p2 = 1'b0;
        logic full = 1'b1;
        int   a, b, c;
        e.wl = 4'd0;
        for (int l = 0; l < 8; l++) begin
            a = lines[l][0]; b = lines[l][1]; c = lines[l][2];
            if (mem[a] == mem[b] && mem[b] == mem[c] && (mem[a] == 2'd1 || mem[a] == 2'd2)) begin
                if (mem[a] == 2'd1) p1 = 1'b1;
                else p2 = 1'b1;
                if (e.wl == 4'd0) e.wl = 4'(l + 1);
            end
        end
        for (int k = 0; k < 9; k++) begin
            if (!(mem[k] == 2'd1 || mem[k] == 2'd2)) full = 1'b0;
        end
        e.w  = {p2, p1};
        e.dr = full && !p1 && !p2;
        e.n  = 0;
        e.due = 0;
        return e;
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s dut%0d cycle=%0d actual=%0d required=%0d", nm, i, cyc, act, req);
        end
    endtask

    // Monitor: compares one DUT's outputs against the scoreboard front.
    task automatic mon(input int i, input logic b, input logic d, input logic [3:0] a,
                       input logic [1:0] w, input logic dr, input logic [3:0] wl);
        exp_t e;
        logic exp_busy, exp_done;
        if (rst) begin
            chk("rst_busy", i, b, 0);
            chk("rst_done", i, d, 0);
            chk("rst_rd_addr", i, a, 0);
            chk("rst_winner", i, w, 0);
            chk("rst_draw", i, dr, 0);
`ifdef GAME_JUDGE_WIN_LINE_EN
            chk("rst_win_line", i, wl, 0);
`endif
            sb[i].delete();
            return;
        end
        exp_busy = 1'b0;
        exp_done = 1'b0;
        if (sb[i].size() > 0) begin
            e = sb[i][0];
            exp_busy = (cyc >= e.n + 1) && (cyc <= e.n + 10 + i);
            exp_done = (cyc == e.due);
        end
        chk("busy", i, b, exp_busy);
        if (sb[i].size() == 0 || cyc <= sb[i][0].n)
            chk("rd_addr_idle", i, a, 0);
        else if (cyc <= sb[i][0].n + 9)
            chk("rd_addr_sweep", i, a, cyc - sb[i][0].n - 1);
        chk("done", i, d, exp_done);
        if (sb[i].size() > 0 && cyc >= sb[i][0].due) begin
            e = sb[i].pop_front();
            if (exp_done && d) begin
                chk("winner", i, w, e.w);
                chk("draw", i, dr, e.dr);
`ifdef GAME_JUDGE_WIN_LINE_EN
                chk("win_line", i, wl, e.wl);
`endif
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, busy0, done0, rd_addr0, winner0, draw0, wl0);
        mon(1, busy1, done1, rd_addr1, winner1, draw1, wl1);
    end

    // Board literal: cell 0 in the top two bits.
    task automatic set_board(input logic [17:0] bits);
        for (int k = 0; k < 9; k++) mem[k] = bits[17 - 2 * k -: 2];
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e = model();
        e.n = cyc;
        e.due = cyc + 11 + i;
        sb[i].push_back(e);
    endtask

    task automatic scan();
        push_exp(0);
        push_exp(1);
        start0 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 80 && (sb[0].size() > 0 || sb[1].size() > 0); k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        start0 = 1'b0; start1 = 1'b0;
        for (int k = 0; k < 9; k++) mem[k] = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Empty board
        scan(); wait_idle();
        // P1 owns row 0
        set_board({2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0});
        scan(); wait_idle();
        // P2 owns column 2
        set_board({2'd1, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd2});
        scan(); wait_idle();
        // P2 owns anti-diagonal only
        set_board({2'd1, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0});
        scan(); wait_idle();
        // Full board, no line -> draw; then cursor at cell 4 -> no draw
        set_board({2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1});
        scan(); wait_idle();
        mem[4] = 2'd3;
        scan(); wait_idle();
        // Conflict; extra start while busy must be ignored
        set_board({2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2});
        scan();
        repeat (4) @(posedge clk);
        #1 start0 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        wait_idle();
        // Reset during READ cycle 5, then a fresh scan completes
        set_board({2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0});
        scan();
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        scan(); wait_idle();
        // start held high: re-triggers right after each DONE
        set_board({2'd0, 2'd2, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd2, 2'd0});
        nxt[0] = cyc; nxt[1] = cyc;
        start0 = 1'b1; start1 = 1'b1;
        for (int k = 0; k < 26; k++) begin
            for (int i = 0; i < 2; i++) begin
                if (cyc == nxt[i]) begin
                    push_exp(i);
                    nxt[i] = nxt[i] + 12 + i;
                end
            end
            @(posedge clk); #1;
        end
        start0 = 1'b0; start1 = 1'b0;
        wait_idle();
        // Random boards; every other one drawn from occupied codes only
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 9; k++)
                mem[k] = (r % 2 == 0) ? 2'($urandom_range(1, 2)) : 2'($urandom_range(0, 3));
            scan(); wait_idle();
        end
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
